// File: rtl/stack_error_lifo.sv
// 4-entry LIFO stack with registered pop data, empty/full flags and an illegal-request error flag.
// Define STACK_ERROR_STICKY_EN to make error sticky until rst; the default build makes it a per-cycle flag.
module stack_error_lifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              empty,
    output logic              full,
    output logic              error
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] write_pointer;
    logic [ADDR_W-1:0] read_pointer;
    logic [DATA_W-1:0] mem [DEPTH];

    logic do_push;
    logic do_pop;
    logic illegal;

    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);

    // Simultaneous push+pop is always illegal, even when one of them alone would be legal.
    assign do_push = push && !pop && !full;
    assign do_pop  = pop && !push && !empty;
    assign illegal = (push && pop) || (push && full) || (pop && empty);

    always_ff @(posedge clk) begin
        if (rst) begin
            count         <= '0;
            write_pointer <= '0;
            read_pointer  <= '1;
            read_data     <= '0;
            error         <= 1'b0;
        end else begin
            if (do_push) begin
                count         <= count + CNT_ONE;
                write_pointer <= write_pointer + PTR_ONE;
                read_pointer  <= read_pointer + PTR_ONE;
            end else if (do_pop) begin
                read_data     <= mem[read_pointer];
                count         <= count - CNT_ONE;
                write_pointer <= write_pointer - PTR_ONE;
                read_pointer  <= read_pointer - PTR_ONE;
            end
`ifdef STACK_ERROR_STICKY_EN
            error <= error || illegal;
`else
            error <= illegal;
`endif
        end
    end

    // Storage carries no reset; writes are blocked while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[write_pointer] <= write_data;
        end
    end

endmodule

// File: tb/tb_stack_error_lifo.sv
// Directed self-checking bench for stack_error_lifo; expectations are hand-computed per scenario.
// Honours STACK_ERROR_STICKY_EN so the same bench covers both error-flag builds.
module tb_stack_error_lifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic       pop;
    logic [7:0] write_data;
    logic [7:0] read_data;
    logic       empty;
    logic       full;
    logic       error;

    int checks = 0;
    int passed = 0;
    // Error level expected after a legal/idle edge: 0 normally, 1 in sticky build once an error was seen.
    logic idle_err = 1'b0;

    stack_error_lifo #(.DATA_W(8), .ADDR_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .write_data (write_data),
        .read_data  (read_data),
        .empty      (empty),
        .full       (full),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic saw_error();
`ifdef STACK_ERROR_STICKY_EN
        idle_err = 1'b1;
`else
        idle_err = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; push = 1'b1; pop = 1'b0; write_data = 8'hAA;
        step();
        step();
        checks++; if (empty !== 1'b1) $display("[TB] FAIL reset_empty got %b want 1", empty); else passed++;
        checks++; if (full !== 1'b0) $display("[TB] FAIL reset_full got %b want 0", full); else passed++;
        checks++; if (read_data !== 8'h00) $display("[TB] FAIL reset_read_data got %h want 00", read_data); else passed++;
        checks++; if (error !== 1'b0) $display("[TB] FAIL reset_error got %b want 0", error); else passed++;
        checks++; if (dut.write_pointer !== 2'd0) $display("[TB] FAIL reset_wp got %0d want 0", dut.write_pointer); else passed++;
        checks++; if (dut.read_pointer !== 2'd3) $display("[TB] FAIL reset_rp got %0d want 3", dut.read_pointer); else passed++;
        rst = 1'b0; push = 1'b0;
        idle_err = 1'b0;
    endtask

    task automatic test_fill();
        logic [1:0] exp_wp;
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; write_data = 8'(i + 2);
            step();
            exp_wp = 2'(i + 1);
            checks++; if (dut.write_pointer !== exp_wp) $display("[TB] FAIL fill_wp_%0d got %0d want %0d", i, dut.write_pointer, exp_wp); else passed++;
            checks++; if (full !== (i == 3)) $display("[TB] FAIL fill_full_%0d got %b want %b", i, full, (i == 3)); else passed++;
        end
        push = 1'b0;
        checks++; if (dut.read_pointer !== 2'd3) $display("[TB] FAIL fill_rp got %0d want 3", dut.read_pointer); else passed++;
        checks++; if (error !== 1'b0) $display("[TB] FAIL fill_error got %b want 0", error); else passed++;
        checks++; if (empty !== 1'b0) $display("[TB] FAIL fill_empty got %b want 0", empty); else passed++;
    endtask

    task automatic test_overflow();
        push = 1'b1; write_data = 8'h06;
        step();
        push = 1'b0;
        saw_error();
        checks++; if (error !== 1'b1) $display("[TB] FAIL ovf_error got %b want 1", error); else passed++;
        checks++; if (dut.count !== 3'd4) $display("[TB] FAIL ovf_count got %0d want 4", dut.count); else passed++;
        checks++; if (dut.write_pointer !== 2'd0) $display("[TB] FAIL ovf_wp got %0d want 0", dut.write_pointer); else passed++;
        step();
        checks++; if (error !== idle_err) $display("[TB] FAIL ovf_error_after got %b want %b", error, idle_err); else passed++;
    endtask

    task automatic test_drain();
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) begin
            pop = 1'b1;
            step();
            exp = 8'(5 - i);
            checks++; if (read_data !== exp) $display("[TB] FAIL drain_data_%0d got %h want %h", i, read_data, exp); else passed++;
            checks++; if (error !== idle_err) $display("[TB] FAIL drain_error_%0d got %b want %b", i, error, idle_err); else passed++;
        end
        pop = 1'b0;
        checks++; if (empty !== 1'b1) $display("[TB] FAIL drain_empty got %b want 1", empty); else passed++;
        checks++; if (dut.read_pointer !== 2'd3) $display("[TB] FAIL drain_rp got %0d want 3", dut.read_pointer); else passed++;
    endtask

    task automatic test_underflow();
        pop = 1'b1;
        step();
        pop = 1'b0;
        saw_error();
        checks++; if (error !== 1'b1) $display("[TB] FAIL udf_error got %b want 1", error); else passed++;
        checks++; if (read_data !== 8'h02) $display("[TB] FAIL udf_read_data got %h want 02", read_data); else passed++;
        checks++; if (dut.write_pointer !== 2'd0) $display("[TB] FAIL udf_wp got %0d want 0", dut.write_pointer); else passed++;
        checks++; if (dut.read_pointer !== 2'd3) $display("[TB] FAIL udf_rp got %0d want 3", dut.read_pointer); else passed++;
        checks++; if (empty !== 1'b1) $display("[TB] FAIL udf_empty got %b want 1", empty); else passed++;
        push = 1'b1; write_data = 8'h11;
        step();
        push = 1'b0;
        checks++; if (error !== idle_err) $display("[TB] FAIL udf_error_after_push got %b want %b", error, idle_err); else passed++;
        checks++; if (empty !== 1'b0) $display("[TB] FAIL udf_push_empty got %b want 0", empty); else passed++;
    endtask

    task automatic test_simultaneous();
        push = 1'b1; write_data = 8'h12;
        step();
        pop = 1'b1; write_data = 8'h99;
        step();
        push = 1'b0; pop = 1'b0;
        saw_error();
        checks++; if (error !== 1'b1) $display("[TB] FAIL simul_error got %b want 1", error); else passed++;
        checks++; if (dut.count !== 3'd2) $display("[TB] FAIL simul_count got %0d want 2", dut.count); else passed++;
        checks++; if (read_data !== 8'h02) $display("[TB] FAIL simul_read_data got %h want 02", read_data); else passed++;
        checks++; if (dut.write_pointer !== 2'd2) $display("[TB] FAIL simul_wp got %0d want 2", dut.write_pointer); else passed++;
        pop = 1'b1;
        step();
        pop = 1'b0;
        checks++; if (read_data !== 8'h12) $display("[TB] FAIL simul_pop_data got %h want 12", read_data); else passed++;
        checks++; if (error !== idle_err) $display("[TB] FAIL simul_error_after got %b want %b", error, idle_err); else passed++;
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; push = 1'b1; write_data = 8'h33;
        step();
        rst = 1'b0; push = 1'b0;
        idle_err = 1'b0;
        checks++; if (dut.count !== 3'd0) $display("[TB] FAIL rmid_count got %0d want 0", dut.count); else passed++;
        checks++; if (empty !== 1'b1) $display("[TB] FAIL rmid_empty got %b want 1", empty); else passed++;
        checks++; if (read_data !== 8'h00) $display("[TB] FAIL rmid_read_data got %h want 00", read_data); else passed++;
        checks++; if (error !== 1'b0) $display("[TB] FAIL rmid_error got %b want 0", error); else passed++;
        checks++; if (dut.read_pointer !== 2'd3) $display("[TB] FAIL rmid_rp got %0d want 3", dut.read_pointer); else passed++;
    endtask

    task automatic test_back_to_back();
        push = 1'b1; write_data = 8'h44;
        step();
        push = 1'b0; pop = 1'b1;
        step();
        pop = 1'b0;
        checks++; if (read_data !== 8'h44) $display("[TB] FAIL b2b_data got %h want 44", read_data); else passed++;
        checks++; if (empty !== 1'b1) $display("[TB] FAIL b2b_empty got %b want 1", empty); else passed++;
        checks++; if (error !== 1'b0) $display("[TB] FAIL b2b_error got %b want 0", error); else passed++;
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; write_data = 8'h00;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_underflow();
        test_simultaneous();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
